sdram_port_arbiter: RTL and testbench

- Burst-level scheduler in front of sdram_control.
- Shares the single SDRAM controller between a write requester (write FIFO side) and a read requester (read FIFO side).
- Generates wrap-around linear burst addresses for each requester, splits them into bank/row/column, and drives the controller's Wr/Rd level requests.
- Holds each request until the controller's Wdata_done/Rdata_done pulse.

---
 rtl/sdram_arb_pkg.sv | 23 ++
 rtl/sdram_port_arbiter_if.sv | 41 ++++
 rtl/sdram_burst_addr_gen.sv | 56 +++++
 rtl/sdram_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter: FSM state encoding,
// served-side tag, the controller burst length and the linear address width.
package sdram_arb_pkg;

  // Must track SC_BL of the sdram_control build.
  localparam int SC_BL = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_BURST = 2'd2
  } arb_state_t;

  typedef enum logic {
    SIDE_WRITE = 1'b0,
    SIDE_READ  = 1'b1
  } side_t;

  function automatic int addr_width(input int bank_bits, input int row_bits, input int col_bits);
    return bank_bits + row_bits + col_bits;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Signal bundle between the arbiter, the FIFO-side requesters and sdram_control.
// dbg_state mirrors the arbiter FSM for checkers.
interface sdram_port_arbiter_if #(
  parameter int ROW_BITS  = 13,
  parameter int BANK_BITS = 2
) ();
  import sdram_arb_pkg::*;

  // Handshake: Wr_req/Rd_req are levels sampled only in IDLE; Sdr_wr/Sdr_rd are
  // levels held with a stable address until the matching *_data_done pulse,
  // then drop for at least one cycle while *_burst_done pulses once.
  logic                 Wr_req;
  logic                 Rd_req;
  logic                 Wr_addr_clr;
  logic                 Rd_addr_clr;
  logic                 Wr_busy;
  logic                 Rd_busy;
  logic                 Wr_burst_done;
  logic                 Rd_burst_done;
  logic                 Sdr_wr;
  logic                 Sdr_rd;
  logic [ROW_BITS-1:0]  Sdr_caddr;
  logic [ROW_BITS-1:0]  Sdr_raddr;
  logic [BANK_BITS-1:0] Sdr_baddr;
  logic                 Sdr_wdata_done;
  logic                 Sdr_rdata_done;
  arb_state_t           dbg_state;

  modport master (
    input  Wr_req, Rd_req, Wr_addr_clr, Rd_addr_clr, Sdr_wdata_done, Sdr_rdata_done,
    output Wr_busy, Rd_busy, Wr_burst_done, Rd_burst_done,
    output Sdr_wr, Sdr_rd, Sdr_caddr, Sdr_raddr, Sdr_baddr, dbg_state
  );

  modport slave (
    output Wr_req, Rd_req, Wr_addr_clr, Rd_addr_clr, Sdr_wdata_done, Sdr_rdata_done,
    input  Wr_busy, Rd_busy, Wr_burst_done, Rd_burst_done,
    input  Sdr_wr, Sdr_rd, Sdr_caddr, Sdr_raddr, Sdr_baddr, dbg_state
  );

endinterface

// File: rtl/sdram_burst_addr_gen.sv
// Wrap-around linear burst pointer for one requester, with deferred clear
// and {bank, row, col} split of the address the next burst will use.
module sdram_burst_addr_gen
  import sdram_arb_pkg::*;
#(
  parameter int          BURST_LEN = SC_BL,
  parameter int          COL_BITS  = 9,
  parameter int          ROW_BITS  = 13,
  parameter int          BANK_BITS = 2,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned END_ADDR  = 24'h0FFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_burst,
  input  logic                 done,
  output logic [ROW_BITS-1:0]  caddr,
  output logic [ROW_BITS-1:0]  raddr,
  output logic [BANK_BITS-1:0] baddr
);

  localparam int AW = addr_width(BANK_BITS, ROW_BITS, COL_BITS);
  localparam logic [AW-1:0] BASE_A = AW'(BASE_ADDR);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] sel_addr;
  logic [AW-1:0] adv_addr;
  logic [AW:0]   sum;
  logic          clr_pend_q;

  // A clear outside our own burst takes effect on the very next grant.
  always_comb begin
    sel_addr = (clr && !in_burst) ? BASE_A : ptr_q;
    sum      = {1'b0, ptr_q} + (AW+1)'(BURST_LEN);
    adv_addr = (sum > (AW+1)'(END_ADDR)) ? BASE_A : sum[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= BASE_A;
      clr_pend_q <= 1'b0;
    end else if (done) begin
      ptr_q      <= (clr || clr_pend_q) ? BASE_A : adv_addr;
      clr_pend_q <= 1'b0;
    end else if (clr) begin
      if (in_burst) clr_pend_q <= 1'b1;
      else          ptr_q      <= BASE_A;
    end
  end

  assign caddr = ROW_BITS'(sel_addr[COL_BITS-1:0]);
  assign raddr = sel_addr[COL_BITS +: ROW_BITS];
  assign baddr = sel_addr[AW-1 -: BANK_BITS];

endmodule

// File: rtl/sdram_port_arbiter.sv
// Burst scheduler sharing one sdram_control between write and read FIFO sides.
// Define SDRAM_ARB_RR_EN for round-robin ties; default is fixed write priority.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int          BURST_LEN = SC_BL,
  parameter int          COL_BITS  = 9,
  parameter int          ROW_BITS  = 13,
  parameter int          BANK_BITS = 2,
  parameter int unsigned WR_BASE   = 0,
  parameter int unsigned WR_END    = 24'h0FFFFF,
  parameter int unsigned RD_BASE   = 0,
  parameter int unsigned RD_END    = 24'h0FFFFF
) (
  input logic                  Clk,
  input logic                  Rst,
  sdram_port_arbiter_if.master bus
);

  arb_state_t           state_q, next_state;
  logic                 wr_q, rd_q, wr_n, rd_n;
  logic                 wdone_q, rdone_q, wdone_n, rdone_n;
  logic [ROW_BITS-1:0]  caddr_q, raddr_q, caddr_n, raddr_n;
  logic [BANK_BITS-1:0] baddr_q, baddr_n;
  logic [ROW_BITS-1:0]  wr_caddr, wr_raddr, rd_caddr, rd_raddr;
  logic [BANK_BITS-1:0] wr_baddr, rd_baddr;
  logic                 in_wr, in_rd, grant_wr, grant_rd;

  assign in_wr = (state_q == ST_WR_BURST);
  assign in_rd = (state_q == ST_RD_BURST);

  sdram_burst_addr_gen #(
    .BURST_LEN(BURST_LEN), .COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS),
    .BANK_BITS(BANK_BITS), .BASE_ADDR(WR_BASE), .END_ADDR(WR_END)
  ) u_wr_addr (
    .clk(Clk), .rst(Rst), .clr(bus.Wr_addr_clr), .in_burst(in_wr),
    .done(in_wr && bus.Sdr_wdata_done),
    .caddr(wr_caddr), .raddr(wr_raddr), .baddr(wr_baddr)
  );

  sdram_burst_addr_gen #(
    .BURST_LEN(BURST_LEN), .COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS),
    .BANK_BITS(BANK_BITS), .BASE_ADDR(RD_BASE), .END_ADDR(RD_END)
  ) u_rd_addr (
    .clk(Clk), .rst(Rst), .clr(bus.Rd_addr_clr), .in_burst(in_rd),
    .done(in_rd && bus.Sdr_rdata_done),
    .caddr(rd_caddr), .raddr(rd_raddr), .baddr(rd_baddr)
  );

`ifdef SDRAM_ARB_RR_EN
  side_t last_q;

  always_ff @(posedge Clk) begin
    if (Rst)                              last_q <= SIDE_READ;
    else if (in_wr && bus.Sdr_wdata_done) last_q <= SIDE_WRITE;
    else if (in_rd && bus.Sdr_rdata_done) last_q <= SIDE_READ;
  end

  assign grant_wr = bus.Wr_req && (!bus.Rd_req || last_q == SIDE_READ);
`else
  assign grant_wr = bus.Wr_req;
`endif
  assign grant_rd = bus.Rd_req && !grant_wr;

  always_comb begin
    next_state = state_q;
    wr_n       = 1'b0;
    rd_n       = 1'b0;
    wdone_n    = 1'b0;
    rdone_n    = 1'b0;
    caddr_n    = caddr_q;
    raddr_n    = raddr_q;
    baddr_n    = baddr_q;
    unique case (state_q)
      ST_IDLE: begin
        caddr_n = '0;
        raddr_n = '0;
        baddr_n = '0;
        if (grant_wr) begin
          next_state = ST_WR_BURST;
          wr_n       = 1'b1;
          caddr_n    = wr_caddr;
          raddr_n    = wr_raddr;
          baddr_n    = wr_baddr;
        end else if (grant_rd) begin
          next_state = ST_RD_BURST;
          rd_n       = 1'b1;
          caddr_n    = rd_caddr;
          raddr_n    = rd_raddr;
          baddr_n    = rd_baddr;
        end
      end
      ST_WR_BURST: begin
        if (bus.Sdr_wdata_done) begin
          next_state = ST_IDLE;
          wdone_n    = 1'b1;
          caddr_n    = '0;
          raddr_n    = '0;
          baddr_n    = '0;
        end else begin
          wr_n = 1'b1;
        end
      end
      ST_RD_BURST: begin
        if (bus.Sdr_rdata_done) begin
          next_state = ST_IDLE;
          rdone_n    = 1'b1;
          caddr_n    = '0;
          raddr_n    = '0;
          baddr_n    = '0;
        end else begin
          rd_n = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      wdone_q <= 1'b0;
      rdone_q <= 1'b0;
      caddr_q <= '0;
      raddr_q <= '0;
      baddr_q <= '0;
    end else begin
      state_q <= next_state;
      wr_q    <= wr_n;
      rd_q    <= rd_n;
      wdone_q <= wdone_n;
      rdone_q <= rdone_n;
      caddr_q <= caddr_n;
      raddr_q <= raddr_n;
      baddr_q <= baddr_n;
    end
  end

  // Busy and the controller request are the same registered level.
  assign bus.Sdr_wr        = wr_q;
  assign bus.Sdr_rd        = rd_q;
  assign bus.Wr_busy       = wr_q;
  assign bus.Rd_busy       = rd_q;
  assign bus.Wr_burst_done = wdone_q;
  assign bus.Rd_burst_done = rdone_q;
  assign bus.Sdr_caddr     = caddr_q;
  assign bus.Sdr_raddr     = raddr_q;
  assign bus.Sdr_baddr     = baddr_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: vector table, contention,
// randomized bursts against an address-map model, and reset/stray-done sequences.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  localparam int          W       = 29;
  localparam int unsigned WR_BASE = 0;
  localparam int unsigned WR_END  = 23;
  localparam int unsigned RD_BASE = 496;
  localparam int unsigned RD_END  = 24'h0FFFFF;
`ifdef SDRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    bit          side;
    int          mode;
    logic [12:0] exp_ca;
    logic [12:0] exp_ra;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [W-1:0] exp_q[$];
  int unsigned wr_ptr, rd_ptr;
  bit          last_side;
  vec_t        vec[15];

  sdram_port_arbiter_if #(.ROW_BITS(13), .BANK_BITS(2)) bus ();

  sdram_port_arbiter #(
    .BURST_LEN(8), .COL_BITS(9), .ROW_BITS(13), .BANK_BITS(2),
    .WR_BASE(WR_BASE), .WR_END(WR_END), .RD_BASE(RD_BASE), .RD_END(RD_END)
  ) dut (
    .Clk(clk), .Rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pkt(input bit side, input int unsigned a);
    logic [1:0]  b;
    logic [12:0] r, c;
    b = 2'((a >> 22) & 3);
    r = 13'((a >> 9) & 8191);
    c = 13'(a & 511);
    return {side, b, r, c};
  endfunction

  function automatic int unsigned next_ptr(input int unsigned p, input int unsigned base,
                                           input int unsigned last, input bit clr);
    if (clr || p + 8 > last) return base;
    return p + 8;
  endfunction

  task automatic model_reset();
    wr_ptr    = WR_BASE;
    rd_ptr    = RD_BASE;
    last_side = 1'b1;
  endtask

  task automatic set_clr(input bit side, input logic v);
    if (side) bus.Rd_addr_clr = v;
    else      bus.Wr_addr_clr = v;
  endtask

  // Act as sdram_control for one burst: wait for the grant, check it, hold, finish it.
  // mode: 0 plain, 1 clear mid-burst, 2 clear with done, 3 clear in IDLE (set by caller).
  task automatic serve(input bit side, input int mode, input bit hold_req,
                       output logic [12:0] ca, output logic [12:0] ra, output bit got);
    int n, hold;
    logic [W-1:0] act, exp_pkt;
    exp_q.push_back(pkt(side, side ? rd_ptr : wr_ptr));
    n = 0;
    ca = '0; ra = '0; got = 1'b0;
    do begin
      tick();
      n++;
      bus.Wr_addr_clr = 1'b0;
      bus.Rd_addr_clr = 1'b0;
      if (n == 1) check("done_pulse_width", {bus.Wr_burst_done, bus.Rd_burst_done}, 0);
    end while (!(bus.Sdr_wr || bus.Sdr_rd) && n < 6);
    check("grant_latency", n, 1);
    if (!(bus.Sdr_wr || bus.Sdr_rd)) begin
      void'(exp_q.pop_front());
      return;
    end
    got = bus.Sdr_rd;
    check("grant_side", {bus.Sdr_rd, bus.Sdr_wr}, side ? 2'b10 : 2'b01);
    check("busy", {bus.Rd_busy, bus.Wr_busy}, side ? 2'b10 : 2'b01);
    act = {bus.Sdr_rd, bus.Sdr_baddr, bus.Sdr_raddr, bus.Sdr_caddr};
    exp_pkt = exp_q.pop_front();
    check("burst_addr", act, exp_pkt);
    ca = bus.Sdr_caddr;
    ra = bus.Sdr_raddr;
    if (!hold_req) begin
      bus.Wr_req = 1'b0;
      bus.Rd_req = 1'b0;
    end
    if (mode == 1) set_clr(side, 1'b1);
    hold = $urandom_range(1, 3);
    for (int i = 0; i < hold; i++) begin
      if (side) bus.Sdr_wdata_done = 1'($urandom_range(0, 1));
      else      bus.Sdr_rdata_done = 1'($urandom_range(0, 1));
      tick();
      bus.Sdr_wdata_done = 1'b0;
      bus.Sdr_rdata_done = 1'b0;
      set_clr(side, 1'b0);
      check("hold_stable",
            {bus.Sdr_rd, bus.Sdr_baddr, bus.Sdr_raddr, bus.Sdr_caddr, bus.Sdr_wr,
             bus.Wr_burst_done, bus.Rd_burst_done},
            {exp_pkt, !side, 2'b00});
    end
    if (side) bus.Sdr_rdata_done = 1'b1;
    else      bus.Sdr_wdata_done = 1'b1;
    if (mode == 2) set_clr(side, 1'b1);
    tick();
    bus.Sdr_wdata_done = 1'b0;
    bus.Sdr_rdata_done = 1'b0;
    set_clr(side, 1'b0);
    check("burst_end",
          {bus.Sdr_wr, bus.Sdr_rd, bus.Wr_busy, bus.Rd_busy, bus.Wr_burst_done, bus.Rd_burst_done},
          side ? 6'b000001 : 6'b000010);
    check("addr_idle", {bus.Sdr_baddr, bus.Sdr_raddr, bus.Sdr_caddr}, 0);
    if (side) rd_ptr = next_ptr(rd_ptr, RD_BASE, RD_END, mode == 1 || mode == 2);
    else      wr_ptr = next_ptr(wr_ptr, WR_BASE, WR_END, mode == 1 || mode == 2);
    last_side = side;
  endtask

  initial begin
    logic [12:0] ca, ra;
    bit          got;
    logic [3:0]  order;
    bit          side;
    int          r, mode;

    vec[0]  = '{0, 0, 13'd0,   13'd0};
    vec[1]  = '{0, 0, 13'd8,   13'd0};
    vec[2]  = '{0, 1, 13'd16,  13'd0};
    vec[3]  = '{0, 0, 13'd0,   13'd0};
    vec[4]  = '{0, 0, 13'd8,   13'd0};
    vec[5]  = '{0, 2, 13'd16,  13'd0};
    vec[6]  = '{0, 0, 13'd0,   13'd0};
    vec[7]  = '{0, 0, 13'd8,   13'd0};
    vec[8]  = '{0, 0, 13'd16,  13'd0};
    vec[9]  = '{0, 0, 13'd0,   13'd0};
    vec[10] = '{1, 0, 13'd496, 13'd0};
    vec[11] = '{1, 0, 13'd504, 13'd0};
    vec[12] = '{1, 0, 13'd0,   13'd1};
    vec[13] = '{1, 3, 13'd496, 13'd0};
    vec[14] = '{1, 0, 13'd504, 13'd0};

    bus.Wr_req = 1'b0; bus.Rd_req = 1'b0;
    bus.Wr_addr_clr = 1'b0; bus.Rd_addr_clr = 1'b0;
    bus.Sdr_wdata_done = 1'b0; bus.Sdr_rdata_done = 1'b0;
    model_reset();
    repeat (3) tick();
    check("reset_outputs",
          {bus.Sdr_wr, bus.Sdr_rd, bus.Wr_busy, bus.Rd_busy, bus.Wr_burst_done,
           bus.Rd_burst_done, bus.Sdr_baddr, bus.Sdr_raddr, bus.Sdr_caddr}, 0);
    check("reset_state", bus.dbg_state, ST_IDLE);
    rst = 1'b0;

    bus.Sdr_wdata_done = 1'b1;
    bus.Sdr_rdata_done = 1'b1;
    tick();
    bus.Sdr_wdata_done = 1'b0;
    bus.Sdr_rdata_done = 1'b0;
    tick();
    check("idle_stray_done", {bus.Wr_burst_done, bus.Rd_burst_done, bus.Sdr_wr, bus.Sdr_rd}, 0);
    check("idle_stray_state", bus.dbg_state, ST_IDLE);

    for (int i = 0; i < 15; i++) begin
      if (vec[i].side) bus.Rd_req = 1'b1;
      else             bus.Wr_req = 1'b1;
      if (vec[i].mode == 3) begin
        set_clr(vec[i].side, 1'b1);
        if (vec[i].side) rd_ptr = RD_BASE;
        else             wr_ptr = WR_BASE;
      end
      serve(vec[i].side, vec[i].mode, 1'b0, ca, ra, got);
      check($sformatf("vec%0d_caddr", i), ca, vec[i].exp_ca);
      check($sformatf("vec%0d_raddr", i), ra, vec[i].exp_ra);
    end

    bus.Wr_req = 1'b1;
    bus.Rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve(RR ? !last_side : 1'b0, 0, 1'b1, ca, ra, got);
      order[i] = got;
    end
    bus.Wr_req = 1'b0;
    bus.Rd_req = 1'b0;
    check("contention_order", order, RR ? 4'b1010 : 4'b0000);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(1, 3);
      bus.Wr_req = r[0];
      bus.Rd_req = r[1];
      if (r == 3) side = RR ? !last_side : 1'b0;
      else        side = (r == 2);
      mode = $urandom_range(0, 3);
      if (mode == 3) begin
        set_clr(side, 1'b1);
        if (side) rd_ptr = RD_BASE;
        else      wr_ptr = WR_BASE;
      end
      serve(side, mode, 1'b0, ca, ra, got);
    end

    bus.Rd_req = 1'b1;
    tick();
    check("rd_grant_before_reset", {bus.Sdr_rd, bus.dbg_state}, {1'b1, ST_RD_BURST});
    bus.Rd_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_mid_burst", {bus.Sdr_rd, bus.Rd_busy, bus.Rd_burst_done, bus.dbg_state},
          {3'b000, ST_IDLE});
    model_reset();
    bus.Rd_req = 1'b1;
    serve(1'b1, 0, 1'b0, ca, ra, got);
    check("rd_ptr_after_reset", ca, 13'd496);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
